// File: rtl/mini_xception_pkg.sv
// Shared constants and FSM encoding for the mini-Xception frame controller.
package mini_xception_pkg;
    localparam int NUM_CLASSES   = 7;
    localparam int CLASS_ID_W    = 3;
    localparam int TIMEOUT_CLASS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_ARGMAX,
        ST_DONE
    } state_t;
endpackage

// File: rtl/class_argmax.sv
// Sequential signed argmax over the seven class scores, one index per cycle.
module class_argmax
    import mini_xception_pkg::*;
#(
    parameter int DATA_WIDHT = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DATA_WIDHT*NUM_CLASSES-1:0] scores,
    output logic                              done,
    output logic [CLASS_ID_W-1:0]             index,
    output logic [DATA_WIDHT-1:0]             score
);
    logic                         active_q, active_d;
    logic [CLASS_ID_W-1:0]        idx_q, idx_d;
    logic [CLASS_ID_W-1:0]        best_idx_q, best_idx_d;
    logic signed [DATA_WIDHT-1:0] best_q, best_d;
    logic signed [DATA_WIDHT-1:0] cand;
    logic                         last;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (idx_q == CLASS_ID_W'(i)) cand = scores[i*DATA_WIDHT +: DATA_WIDHT];
        end
        last       = active_q && (idx_q == CLASS_ID_W'(NUM_CLASSES - 1));
        active_d   = active_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (start) begin
            active_d = 1'b1;
            idx_d    = '0;
        end else if (active_q) begin
            // Strictly-greater keeps the lowest index on ties.
            if (idx_q == '0 || cand > best_q) begin
                best_d     = cand;
                best_idx_d = idx_q;
            end
            idx_d = idx_q + 1'b1;
            if (last) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q   <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else begin
            active_q   <= active_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
        end
    end

    // Result includes the final index compared in the last scan cycle.
    assign done  = last;
    assign index = best_idx_d;
    assign score = best_d;
endmodule

// File: rtl/mini_xception_ctrl.sv
// Frame controller: streams a frame to the network, waits for scores with a
// timeout, and reports the winning class via a sequential argmax.
module mini_xception_ctrl
    import mini_xception_pkg::*;
#(
    parameter int DATA_WIDHT     = 32,
    parameter int IMG_WIDHT      = 48,
    parameter int IMG_HEIGHT     = 48,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic [$clog2(IMG_WIDHT*IMG_HEIGHT)-1:0] mem_addr,
    output logic                                   mem_rd_en,
    input  logic [DATA_WIDHT-1:0]                  mem_rd_data,
    output logic [DATA_WIDHT-1:0]                  net_Data_In,
    output logic                                   net_Valid_In,
    input  logic [DATA_WIDHT*7-1:0]                net_Data_Out,
    input  logic                                   net_Valid_Out,
    output logic [2:0]                             class_id,
    output logic [DATA_WIDHT-1:0]                  class_score,
    output logic                                   done,
    output logic                                   timeout
);
    localparam int N  = IMG_WIDHT * IMG_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     feed_cnt_q, feed_cnt_d;
    logic [TW-1:0]                     wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDHT*NUM_CLASSES-1:0] scores_q, scores_d;
    logic [CLASS_ID_W-1:0]             class_id_q, class_id_d;
    logic [DATA_WIDHT-1:0]             class_score_q, class_score_d;
    logic                              timeout_q, timeout_d;
    logic                              valid_in_q;
    logic                              am_start, am_done;
    logic [CLASS_ID_W-1:0]             am_index;
    logic [DATA_WIDHT-1:0]             am_score;

    assign busy         = (state_q != ST_IDLE);
    assign mem_rd_en    = (state_q == ST_FEED) && (feed_cnt_q < CW'(N));
    assign mem_addr     = mem_rd_en ? feed_cnt_q[AW-1:0] : '0;
    assign net_Data_In  = mem_rd_data;
    assign net_Valid_In = valid_in_q;
    assign class_id     = class_id_q;
    assign class_score  = class_score_q;
    assign timeout      = timeout_q;
    assign done         = (state_q == ST_DONE);

    always_comb begin
        state_d       = state_q;
        feed_cnt_d    = feed_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        scores_d      = scores_q;
        class_id_d    = class_id_q;
        class_score_d = class_score_q;
        timeout_d     = timeout_q;
        am_start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FEED;
                    feed_cnt_d    = '0;
                    class_id_d    = '0;
                    class_score_d = '0;
                    timeout_d     = 1'b0;
                end
            end
            ST_FEED: begin
                // Extra cycle at count N lets the last registered valid drain.
                if (feed_cnt_q == CW'(N)) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (net_Valid_Out) begin
                    scores_d = net_Data_Out;
                    am_start = 1'b1;
                    state_d  = ST_ARGMAX;
                end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_DONE;
                    class_id_d    = CLASS_ID_W'(TIMEOUT_CLASS);
                    class_score_d = '0;
                    timeout_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ARGMAX: begin
                if (am_done) begin
                    state_d       = ST_DONE;
                    class_id_d    = am_index;
                    class_score_d = am_score;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            feed_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            scores_q      <= '0;
            class_id_q    <= '0;
            class_score_q <= '0;
            timeout_q     <= 1'b0;
            valid_in_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            feed_cnt_q    <= feed_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            scores_q      <= scores_d;
            class_id_q    <= class_id_d;
            class_score_q <= class_score_d;
            timeout_q     <= timeout_d;
            valid_in_q    <= mem_rd_en;
        end
    end

    class_argmax #(
        .DATA_WIDHT(DATA_WIDHT)
    ) u_argmax (
        .clk   (clk),
        .rst   (rst),
        .start (am_start),
        .scores(scores_q),
        .done  (am_done),
        .index (am_index),
        .score (am_score)
    );
endmodule
